puzzle_loader: RTL and testbench
================================

Name: puzzle_loader

Overview:
- Front end of the solver. Accepts the puzzle as a serial stream of decimal digits over a valid/ready handshake, one cell per transfer.
- Decodes each digit into the one-hot cell encoding the solver core uses. This is the inverse of the per-cell one-hot-to-digit encoder on the solver output.
- Assembles the full grid onto initial_vals, then issues a single-cycle start pulse that makes the solver cells latch their initial values.
- Flags malformed puzzles instead of starting the solver.

Parameters:
WIDTH, 9, grid side length and one-hot width per cell (values 1..WIDTH)
DIGIT_W, 4, width of the serial digit bus; must satisfy 2**DIGIT_W > WIDTH

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
digit_in  input  DIGIT_W  cell value: 0 = blank, 1..WIDTH = given digit
digit_valid  input  1  digit_in holds a cell value
digit_ready  output  1  loader accepts a digit this cycle
rearm  input  1  synchronous request to clear the grid and begin a new load
initial_vals  output  WIDTH*WIDTH*WIDTH  packed [row][col][bit] one-hot grid to the solver
start  output  1  one-cycle pulse; grid is complete and valid
busy  output  1  high in LOAD once at least one cell is accepted, until start or error
bad_digit  output  1  sticky; at least one digit_in value exceeded WIDTH in this load
cell_idx  output  7  number of cells accepted so far in this load (0..WIDTH*WIDTH)

Behaviour:
- Reset (async, any state):
  - State = LOAD; cell_idx = 0; initial_vals = all zero.
  - start = 0; busy = 0; bad_digit = 0.
  - digit_ready = 1 after reset deasserts.
- Transfer occurs on a rising edge with digit_valid && digit_ready.
- Cell mapping:
  - Cell k = cell_idx at the time of transfer.
  - Written to row k / WIDTH, col k % WIDTH (row-major, row 0 col 0 first).
- Decode:
  - 0 gives an all-zero cell.
  - d in 1..WIDTH gives bit d-1 set.
  - d > WIDTH writes an all-zero cell and sets bad_digit, which holds until reset or rearm.
- Each written cell updates in the cycle after its transfer. Cells not yet written stay zero.
- States:
  - LOAD:
    - digit_ready = 1.
    - Each transfer increments cell_idx.
    - On the transfer that makes cell_idx == WIDTH*WIDTH: go to FIRE if bad_digit is clear and this digit is legal; otherwise go to ERROR.
  - FIRE (one cycle):
    - start = 1; digit_ready = 0; initial_vals stable.
    - Go to DONE next cycle.
  - DONE:
    - digit_ready = 0; start = 0.
    - initial_vals is held unchanged indefinitely.
  - ERROR:
    - digit_ready = 0; start never asserts.
    - bad_digit = 1; initial_vals held.
- rearm:
  - In any state, rearm high at a clock edge clears initial_vals, cell_idx and bad_digit, and enters LOAD.
  - rearm takes priority over a simultaneous transfer; that digit is dropped.
  - rearm during FIRE suppresses nothing already driven; start was high for that cycle.
- Latency: the final transfer at edge T gives start = 1 during the cycle after edge T. Exactly one pulse per complete load.
- Outputs are registered. start, digit_ready and busy are state decodes with no combinational path from digit_valid.
- digit_valid while digit_ready = 0 is ignored. The source must hold the digit; nothing is consumed.
- cell_idx saturates at WIDTH*WIDTH and never wraps.

Test Plan:
- Reset, then stream 81 digits of a known puzzle with digit_valid held high:
  - Accepts one digit per cycle.
  - initial_vals[0][1] == 9'b010000000 for digit 8.
  - start high exactly one cycle, the cycle after the 81st transfer.
  - digit_ready == 0 afterwards.
- Stream with digit_valid toggled randomly (about 50%): same final grid and single start pulse as the back-to-back case. cell_idx == 81 at start.
- Digit 12 at cell 40, all other digits legal:
  - bad_digit rises the cycle after that transfer; initial_vals[4][4] == 0.
  - After cell 81 the state is ERROR; start never pulses.
- After DONE, pulse rearm:
  - initial_vals == 0, cell_idx == 0, digit_ready == 1.
  - A second full load produces a second start pulse.
- Assert rearm in the same cycle as a valid transfer at cell 10: cell_idx == 0 and the digit is not written.
- Assert reset asynchronously mid-load at cell 30, between clock edges:
  - Outputs clear immediately; start stays 0.
  - A fresh 81-cell load then completes normally.

Source files
------------

// File: rtl/puzzle_loader.sv
// puzzle_loader
// Front end of the solver. Takes the puzzle one cell per valid/ready transfer
// as a decimal digit, decodes it to the solver's one-hot cell encoding (the
// inverse of the solver's one-hot-to-digit output encoder), assembles the full
// grid on initial_vals and then issues a one-cycle start pulse. A puzzle
// containing an out-of-range digit parks in ERROR instead of starting.
//
// Ports:
//   clock        system clock, all state on the rising edge
//   reset        asynchronous active-high reset, clears all state
//   digit_in     cell value: 0 = blank, 1..WIDTH = given digit
//   digit_valid  digit_in holds a cell value
//   digit_ready  loader accepts a digit this cycle (high only in LOAD)
//   rearm        synchronous clear of the grid and restart of the load
//   initial_vals packed [row][col][bit] one-hot grid to the solver
//   start        one-cycle pulse: grid complete and valid
//   busy         in LOAD with at least one cell accepted
//   bad_digit    sticky: some digit in this load exceeded WIDTH
//   cell_idx     cells accepted so far in this load (0..WIDTH*WIDTH)
module puzzle_loader #(
    parameter int WIDTH   = 9,
    parameter int DIGIT_W = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [DIGIT_W-1:0]             digit_in,
    input  logic                           digit_valid,
    output logic                           digit_ready,
    input  logic                           rearm,
    output logic [WIDTH*WIDTH*WIDTH-1:0]   initial_vals,
    output logic                           start,
    output logic                           busy,
    output logic                           bad_digit,
    output logic [6:0]                     cell_idx
);

    localparam int         CELLS      = WIDTH * WIDTH;
    localparam logic [6:0] LAST_CELL  = 7'(CELLS - 1);
    localparam logic [6:0] FULL_COUNT = 7'(CELLS);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                         state_reg, state_next;
    logic [6:0]                     cell_idx_reg, cell_idx_next;
    logic                           bad_digit_reg, bad_digit_next;
    logic [CELLS*WIDTH-1:0]         grid_reg, grid_next;

    logic [WIDTH-1:0]               digit_onehot;
    logic                           digit_legal;
    logic                           xfer;
    logic                           last_xfer;

    // ------------------------------------------------------------------
    // Digit decode: 0 -> blank, d in 1..WIDTH -> bit d-1, larger -> blank
    // and flagged illegal.
    // ------------------------------------------------------------------
    always_comb begin
        digit_onehot = '0;
        digit_legal  = (digit_in <= DIGIT_W'(WIDTH));
        for (int i = 0; i < WIDTH; i++) begin
            if (digit_in == DIGIT_W'(i + 1)) begin
                digit_onehot[i] = 1'b1;
            end
        end
    end

    // digit_ready is a pure state decode, so a transfer is valid && LOAD.
    assign xfer      = digit_valid && (state_reg == ST_LOAD);
    assign last_xfer = xfer && (cell_idx_reg == LAST_CELL);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (rearm) begin
            state_next = ST_LOAD;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (last_xfer) begin
                        // The final digit itself must be legal too; its
                        // bad flag is not visible in bad_digit_reg yet.
                        if (bad_digit_reg || !digit_legal) begin
                            state_next = ST_ERROR;
                        end else begin
                            state_next = ST_FIRE;
                        end
                    end
                end
                ST_FIRE:  state_next = ST_DONE;
                ST_DONE:  state_next = ST_DONE;
                ST_ERROR: state_next = ST_ERROR;
                default:  state_next = ST_LOAD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counter and sticky error flag; rearm wins over a same-cycle transfer.
    // ------------------------------------------------------------------
    always_comb begin
        cell_idx_next  = cell_idx_reg;
        bad_digit_next = bad_digit_reg;
        if (rearm) begin
            cell_idx_next  = '0;
            bad_digit_next = 1'b0;
        end else if (xfer) begin
            if (cell_idx_reg != FULL_COUNT) begin
                cell_idx_next = cell_idx_reg + 7'd1;
            end
            if (!digit_legal) begin
                bad_digit_next = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grid: each cell only loads when the transfer targets its index.
    // Cell k sits at bits k*WIDTH, i.e. row k/WIDTH, col k%WIDTH.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
            assign grid_next[gi*WIDTH +: WIDTH] =
                rearm                                  ? '0 :
                (xfer && (cell_idx_reg == 7'(gi)))     ? digit_onehot :
                                                         grid_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cell_idx_reg  <= '0;
            bad_digit_reg <= 1'b0;
            grid_reg      <= '0;
        end else begin
            cell_idx_reg  <= cell_idx_next;
            bad_digit_reg <= bad_digit_next;
            grid_reg      <= grid_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decodes of registered state only.
    // ------------------------------------------------------------------
    assign digit_ready  = (state_reg == ST_LOAD);
    assign start        = (state_reg == ST_FIRE);
    assign busy         = (state_reg == ST_LOAD) && (cell_idx_reg != 7'd0);
    assign bad_digit    = bad_digit_reg;
    assign cell_idx     = cell_idx_reg;
    assign initial_vals = grid_reg;

endmodule

// File: tb/tb_puzzle_loader.sv
module tb_puzzle_loader;

    localparam int W = 9;
    localparam int N = W * W;
    localparam int GB = N * W;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      digit_in = 4'd0;
    logic            digit_valid = 1'b0;
    logic            digit_ready;
    logic            rearm = 1'b0;
    logic [GB-1:0]   initial_vals;
    logic            start;
    logic            busy;
    logic            bad_digit;
    logic [6:0]      cell_idx;

    int total = 0;
    int bad   = 0;

    int            digits[N];
    logic [GB-1:0] exp_grid;

    typedef struct {
        logic [3:0] d;
        logic [8:0] exp_cell;
        logic       exp_bad;
    } vec_t;
    vec_t tbl[12];

    puzzle_loader #(.WIDTH(W), .DIGIT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .rearm        (rearm),
        .initial_vals (initial_vals),
        .start        (start),
        .busy         (busy),
        .bad_digit    (bad_digit),
        .cell_idx     (cell_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [GB-1:0] act, input logic [GB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the digit rules.
    function automatic logic [8:0] oh(input int d);
        logic [8:0] r;
        r = '0;
        if (d >= 1 && d <= W) r[d-1] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Stream digits[0..ncells-1] from an empty grid; valid asserted with
    // probability pct%. Every cycle the whole observable state is compared
    // with a model built from the count of accepted cells.
    task automatic stream(input int pct, input int ncells, input string tag);
        int cnt;
        int cyc;
        bit bflag;
        bit v;
        cnt = 0;
        cyc = 0;
        bflag = 0;
        exp_grid = '0;
        while (cnt < ncells && cyc < 4000) begin
            v = ($urandom_range(99) < pct);
            digit_in = 4'(digits[cnt]);
            digit_valid = v;
            tick();
            cyc++;
            if (v) begin
                exp_grid[cnt*W +: W] = oh(digits[cnt]);
                if (digits[cnt] > W) bflag = 1;
                cnt++;
            end
            chk({tag, " cell_idx"}, GB'(cell_idx), GB'(cnt));
            chk({tag, " bad_digit"}, GB'(bad_digit), GB'(bflag));
            chk({tag, " grid"}, initial_vals, exp_grid);
            chk({tag, " start"}, GB'(start), GB'(cnt == N && !bflag));
            chk({tag, " busy"}, GB'(busy), GB'(cnt > 0 && cnt < N));
            chk({tag, " ready"}, GB'(digit_ready), GB'(cnt < N));
        end
        digit_valid = 1'b0;
        if (cnt < ncells) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d cells want %0d", tag, cnt, ncells);
        end
        $display("load %s: pct=%0d cells=%0d cycles=%0d", tag, pct, cnt, cyc);
    endtask

    // After a complete load: no further start, nothing accepted even with
    // valid held high, grid frozen.
    task automatic finish_checks(input string tag, input bit fired);
        digit_in = 4'd3;
        digit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, " post start"}, GB'(start), '0);
            chk({tag, " post ready"}, GB'(digit_ready), '0);
            chk({tag, " post cell_idx"}, GB'(cell_idx), GB'(N));
            chk({tag, " post grid"}, initial_vals, exp_grid);
            chk({tag, " post bad_digit"}, GB'(bad_digit), GB'(!fired));
        end
        digit_valid = 1'b0;
    endtask

    task automatic do_rearm(input string tag);
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk({tag, " rearm grid"}, initial_vals, '0);
        chk({tag, " rearm cell_idx"}, GB'(cell_idx), '0);
        chk({tag, " rearm ready"}, GB'(digit_ready), GB'(1));
        chk({tag, " rearm bad"}, GB'(bad_digit), '0);
        chk({tag, " rearm busy"}, GB'(busy), '0);
    endtask

    task automatic load_known();
        string s;
        s = "580070000600195000098000060800060003400080001700020006060000280000419005000080079";
        for (int i = 0; i < N; i++) digits[i] = int'(s[i]) - 48;
    endtask

    initial begin
        tbl[0]  = '{4'd0,  9'h000, 1'b0};
        tbl[1]  = '{4'd1,  9'h001, 1'b0};
        tbl[2]  = '{4'd2,  9'h002, 1'b0};
        tbl[3]  = '{4'd3,  9'h004, 1'b0};
        tbl[4]  = '{4'd4,  9'h008, 1'b0};
        tbl[5]  = '{4'd5,  9'h010, 1'b0};
        tbl[6]  = '{4'd6,  9'h020, 1'b0};
        tbl[7]  = '{4'd7,  9'h040, 1'b0};
        tbl[8]  = '{4'd8,  9'h080, 1'b0};
        tbl[9]  = '{4'd9,  9'h100, 1'b0};
        tbl[10] = '{4'd10, 9'h000, 1'b1};
        tbl[11] = '{4'd15, 9'h000, 1'b1};

        // Reset
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;
        tick();
        chk("reset ready", GB'(digit_ready), GB'(1));
        chk("reset start", GB'(start), '0);
        chk("reset busy", GB'(busy), '0);
        chk("reset bad", GB'(bad_digit), '0);
        chk("reset cell_idx", GB'(cell_idx), '0);
        chk("reset grid", initial_vals, '0);
        $display("reset: ready=%0b cell_idx=%0d", digit_ready, cell_idx);

        // Single-cell decode table
        for (int i = 0; i < 12; i++) begin
            do_rearm("tbl");
            digit_in = tbl[i].d;
            digit_valid = 1'b1;
            tick();
            digit_valid = 1'b0;
            chk("tbl cell0", GB'(initial_vals[8:0]), GB'(tbl[i].exp_cell));
            chk("tbl rest", GB'(initial_vals[GB-1:9]), '0);
            chk("tbl bad", GB'(bad_digit), GB'(tbl[i].exp_bad));
            chk("tbl cell_idx", GB'(cell_idx), GB'(1));
            chk("tbl busy", GB'(busy), GB'(1));
            $display("tbl digit=%0d cell=%03h bad=%0b", tbl[i].d, initial_vals[8:0], bad_digit);
        end

        // Known puzzle, back to back
        do_rearm("b2b");
        load_known();
        stream(100, N, "b2b");
        chk("b2b cell01", GB'(initial_vals[9 +: 9]), GB'(9'b010000000));
        finish_checks("b2b", 1'b1);

        // Rearm from DONE, second load with random valid gaps
        do_rearm("done");
        stream(50, N, "gappy");
        finish_checks("gappy", 1'b1);

        // Illegal digit at cell 40
        do_rearm("bad40");
        load_known();
        digits[40] = 12;
        stream(100, N, "bad40");
        chk("bad40 cell44", GB'(initial_vals[360 +: 9]), '0);
        finish_checks("bad40", 1'b0);

        // rearm colliding with a transfer at cell 10
        do_rearm("coll");
        load_known();
        stream(100, 10, "coll");
        digit_in = 4'd5;
        digit_valid = 1'b1;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        digit_valid = 1'b0;
        chk("coll cell_idx", GB'(cell_idx), '0);
        chk("coll grid", initial_vals, '0);
        chk("coll ready", GB'(digit_ready), GB'(1));
        tick();
        chk("coll cell_idx2", GB'(cell_idx), '0);
        chk("coll grid2", initial_vals, '0);
        $display("collision: cell_idx=%0d", cell_idx);

        // Asynchronous reset mid-load at cell 30
        stream(100, 30, "part30");
        #2 reset = 1'b1;
        #1;
        chk("areset cell_idx", GB'(cell_idx), '0);
        chk("areset grid", initial_vals, '0);
        chk("areset start", GB'(start), '0);
        chk("areset busy", GB'(busy), '0);
        chk("areset bad", GB'(bad_digit), '0);
        #1 reset = 1'b0;
        tick();
        chk("areset start2", GB'(start), '0);
        chk("areset ready", GB'(digit_ready), GB'(1));
        $display("async reset: cell_idx=%0d", cell_idx);

        // Fresh random legal puzzle after reset
        for (int i = 0; i < N; i++) digits[i] = int'($urandom_range(0, W));
        stream(70, N, "rand");
        finish_checks("rand", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
